// File: rtl/i2s_receiver.sv
// i2s_receiver -- I2S serial audio receiver, sclk domain only.
//
// Detects lrclk transitions, waits out the transmitter's one-bit delay, then
// shifts DATA_W bits (MSB first) into a word that is delivered to the
// left_data or right_data register according to the lrclk level of the slot.
//
// Parameters:
//   DATA_W   sample word width in bits (8..32)
//   LEFT_LR  lrclk level that denotes the left channel
// Ports:
//   sclk        bit clock, all logic on its rising edge
//   rst         asynchronous active-high reset
//   lrclk       word select from the I2S master
//   sdin        serial data, MSB first
//   left_data   last complete left word
//   right_data  last complete right word
//   data_valid  one-cycle pulse when a word completes
//   data_ch     channel of the completed word (0 = left, 1 = right)
//   frame_err   one-cycle pulse when a word is truncated by an lrclk edge
//
// Optional feature: define I2S_RX_FRAME_ERR_EN to enable truncation
// detection (an lrclk edge mid-word discards the partial word, pulses
// frame_err and restarts capture for the new channel). Without the macro,
// mid-word edges are ignored and frame_err is constant 0.

module i2s_receiver #(
    parameter int   DATA_W  = 24,
    parameter logic LEFT_LR = 1'b0
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              lrclk,
    input  logic              sdin,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              data_valid,
    output logic              data_ch,
    output logic              frame_err
);

`ifdef I2S_RX_FRAME_ERR_EN
    localparam bit FRAME_ERR_EN = 1'b1;
`else
    localparam bit FRAME_ERR_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t            state;
    logic              prev_lr;
    logic              cur_ch;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shift_reg;

    logic              lr_edge;
    logic              new_ch;
    logic              truncate;
    logic [DATA_W-1:0] word_next;

    assign lr_edge   = prev_lr ^ lrclk;
    assign new_ch    = (lrclk != LEFT_LR);
    // Only a mid-word edge counts as truncation, and only when enabled.
    assign truncate  = FRAME_ERR_EN && lr_edge;
    // Word as it stands once the current sdin sample is shifted in.
    assign word_next = {shift_reg[DATA_W-2:0], sdin};

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            // Track lrclk during reset so its release never looks like an edge.
            prev_lr    <= lrclk;
            cur_ch     <= 1'b0;
            cnt        <= '0;
            shift_reg  <= '0;
            left_data  <= '0;
            right_data <= '0;
            data_valid <= 1'b0;
            data_ch    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            prev_lr    <= lrclk;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (lr_edge) begin
                        state  <= DELAY;
                        cur_ch <= new_ch;
                    end
                end

                DELAY: begin
                    if (truncate) begin
                        frame_err <= 1'b1;
                        cur_ch    <= new_ch;
                        state     <= DELAY;
                    end else begin
                        cnt   <= CNT_LOAD;
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (truncate) begin
                        // Partial word is dropped; the new slot gets its own delay bit.
                        frame_err <= 1'b1;
                        cur_ch    <= new_ch;
                        state     <= DELAY;
                    end else begin
                        shift_reg <= word_next;
                        cnt       <= cnt - CNT_W'(1);
                        if (cnt == '0) begin
                            if (cur_ch) begin
                                right_data <= word_next;
                            end else begin
                                left_data <= word_next;
                            end
                            data_valid <= 1'b1;
                            data_ch    <= cur_ch;
                            state      <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver -- self-checking bench for i2s_receiver (DATA_W = 24,
// LEFT_LR = 0). Drives 32-sclk I2S slots with the word's MSB sampled two
// rising edges after the edge that first sees the new lrclk level, random
// sdin outside the word window, and compares the delivered words with a
// per-slot expected list. Build with or without I2S_RX_FRAME_ERR_EN; the
// truncation scenario picks its expectations to match.

module tb_i2s_receiver;

    localparam int DW   = 24;
    localparam int SLOT = 32;

    logic          sclk  = 1'b0;
    logic          rst   = 1'b0;
    logic          lrclk = 1'b1;
    logic          sdin  = 1'b0;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          data_valid;
    logic          data_ch;
    logic          frame_err;

    i2s_receiver #(
        .DATA_W (DW),
        .LEFT_LR(1'b0)
    ) dut (
        .sclk      (sclk),
        .rst       (rst),
        .lrclk     (lrclk),
        .sdin      (sdin),
        .left_data (left_data),
        .right_data(right_data),
        .data_valid(data_valid),
        .data_ch   (data_ch),
        .frame_err (frame_err)
    );

    always #5 sclk = ~sclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          ch;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } ev_t;

    ev_t           got_q[$];
    ev_t           exp_q[$];
    logic [DW-1:0] m_left  = '0;
    logic [DW-1:0] m_right = '0;
    int            fe_pulses = 0;
    logic          sd_hist[int];
    int            cyc = 0;

    // Observe outputs on the falling edge, away from the sampling edge.
    // A pulse longer than one cycle shows up as an extra entry.
    always @(negedge sclk) begin
        if (!rst) begin
            if (data_valid === 1'b1) got_q.push_back('{data_ch, left_data, right_data});
            if (frame_err === 1'b1) fe_pulses++;
        end
    end

    task automatic drive(input logic lr, input logic sd);
        @(negedge sclk);
        lrclk = lr;
        sdin  = sd;
        sd_hist[cyc] = sd;
        cyc++;
    endtask

    // Drive len cycles of a slot: word bit DW-1-k sits in slot cycle k+2.
    task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int len);
        for (int j = 0; j < len; j++) begin
            if (j >= 2 && j < 2 + DW) drive(lr, w[DW-1-(j-2)]);
            else                      drive(lr, 1'($urandom));
        end
    endtask

    // Reference: a completed word replaces its channel's register only.
    task automatic expect_word(input logic ch, input logic [DW-1:0] w);
        if (ch) m_right = w;
        else    m_left  = w;
        exp_q.push_back('{ch, m_left, m_right});
    endtask

    task automatic do_reset(input int n);
        @(negedge sclk);
        rst = 1'b1;
        repeat (n) drive(lrclk, 1'($urandom));
        rst = 1'b0;
        m_left  = '0;
        m_right = '0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        lrclk = 1'b1;
        #1 rst = 1'b1;
        repeat (3) drive(1'b1, 1'($urandom));
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        checks++; if (left_data !== '0) begin errors++; $display("FAIL reset_left: got %h expected 0", left_data); end
        checks++; if (right_data !== '0) begin errors++; $display("FAIL reset_right: got %h expected 0", right_data); end
        rst = 1'b0;
        got_q.delete();
        fe_pulses = 0;
        repeat (40) drive(1'b1, 1'($urandom));
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL idle_words: got %0d expected 0", got_q.size()); end
        checks++; if (left_data !== '0 || right_data !== '0) begin errors++; $display("FAIL idle_data: got %h/%h expected 0/0", left_data, right_data); end
        checks++; if (data_ch !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL idle_flags: got ch=%b fe=%b expected 0/0", data_ch, frame_err); end
        checks++; if (fe_pulses !== 0) begin errors++; $display("FAIL idle_frame_err: got %0d expected 0", fe_pulses); end
    endtask

    task automatic test_directed();
        got_q.delete(); exp_q.delete();
        send_slot(1'b0, 24'hA5C3F1, SLOT); expect_word(1'b0, 24'hA5C3F1);
        send_slot(1'b1, 24'h123456, SLOT); expect_word(1'b1, 24'h123456);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL directed_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i].ch !== exp_q[i].ch) begin errors++; $display("FAIL directed_ch[%0d]: got %b expected %b", i, got_q[i].ch, exp_q[i].ch); end
            checks++; if (got_q[i].l !== exp_q[i].l) begin errors++; $display("FAIL directed_left[%0d]: got %h expected %h", i, got_q[i].l, exp_q[i].l); end
            checks++; if (got_q[i].r !== exp_q[i].r) begin errors++; $display("FAIL directed_right[%0d]: got %h expected %h", i, got_q[i].r, exp_q[i].r); end
        end
    endtask

    task automatic test_loopback();
        got_q.delete(); exp_q.delete();
        repeat (4) begin
            send_slot(1'b0, 24'h800001, SLOT); expect_word(1'b0, 24'h800001);
            send_slot(1'b1, 24'h800001, SLOT); expect_word(1'b1, 24'h800001);
        end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL loop_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i].ch !== exp_q[i].ch) begin errors++; $display("FAIL loop_ch[%0d]: got %b expected %b", i, got_q[i].ch, exp_q[i].ch); end
            checks++; if (got_q[i].l !== exp_q[i].l) begin errors++; $display("FAIL loop_left[%0d]: got %h expected %h", i, got_q[i].l, exp_q[i].l); end
            checks++; if (got_q[i].r !== exp_q[i].r) begin errors++; $display("FAIL loop_right[%0d]: got %h expected %h", i, got_q[i].r, exp_q[i].r); end
        end
        checks++; if (left_data !== right_data) begin errors++; $display("FAIL loop_match: got %h expected %h", left_data, right_data); end
    endtask

    task automatic test_random();
        logic [DW-1:0] w;
        int fe0;
        got_q.delete(); exp_q.delete();
        fe0 = fe_pulses;
        repeat (6) begin
            w = DW'($urandom); send_slot(1'b0, w, SLOT); expect_word(1'b0, w);
            w = DW'($urandom); send_slot(1'b1, w, SLOT); expect_word(1'b1, w);
        end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i].ch !== exp_q[i].ch) begin errors++; $display("FAIL random_ch[%0d]: got %b expected %b", i, got_q[i].ch, exp_q[i].ch); end
            checks++; if (got_q[i].l !== exp_q[i].l) begin errors++; $display("FAIL random_left[%0d]: got %h expected %h", i, got_q[i].l, exp_q[i].l); end
            checks++; if (got_q[i].r !== exp_q[i].r) begin errors++; $display("FAIL random_right[%0d]: got %h expected %h", i, got_q[i].r, exp_q[i].r); end
        end
        checks++; if (fe_pulses !== fe0) begin errors++; $display("FAIL random_frame_err: got %0d expected %0d", fe_pulses - fe0, 0); end
    endtask

    task automatic test_reset_mid_word();
        logic [DW-1:0] wl, wr;
        wl = DW'($urandom);
        wr = DW'($urandom);
        do_reset(3);
        // Bits 0..9 of the left word are sampled, reset lands on bit 10.
        send_slot(1'b0, wl, 12);
        rst = 1'b1;
        repeat (3) drive(1'b0, 1'($urandom));
        rst = 1'b0;
        repeat (SLOT - 15) drive(1'b0, 1'($urandom));
        send_slot(1'b1, wr, SLOT); expect_word(1'b1, wr);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i].ch !== exp_q[i].ch) begin errors++; $display("FAIL rstmid_ch[%0d]: got %b expected %b", i, got_q[i].ch, exp_q[i].ch); end
            checks++; if (got_q[i].l !== exp_q[i].l) begin errors++; $display("FAIL rstmid_left[%0d]: got %h expected %h", i, got_q[i].l, exp_q[i].l); end
            checks++; if (got_q[i].r !== exp_q[i].r) begin errors++; $display("FAIL rstmid_right[%0d]: got %h expected %h", i, got_q[i].r, exp_q[i].r); end
        end
        checks++; if (left_data !== '0) begin errors++; $display("FAIL rstmid_left_final: got %h expected 0", left_data); end
    endtask

    task automatic test_frame_err();
        logic [DW-1:0] wa, wb, wc, comp;
        int n0, fe0, fe_exp;
        wa = DW'($urandom);
        wb = DW'($urandom);
        wc = DW'($urandom);
        got_q.delete(); exp_q.delete();
        fe0 = fe_pulses;
        n0  = cyc;
        // Left slot cut short: lrclk flips where word bit 12 would be sampled.
        send_slot(1'b0, wa, 14);
        send_slot(1'b1, wb, SLOT);
        send_slot(1'b0, wc, SLOT);
        repeat (4) drive(1'b0, 1'($urandom));
`ifdef I2S_RX_FRAME_ERR_EN
        fe_exp = 1;
        expect_word(1'b1, wb);
        expect_word(1'b0, wc);
`else
        fe_exp = 0;
        // The left word runs to completion over whatever sdin carried.
        for (int i = 0; i < DW; i++) comp[DW-1-i] = sd_hist[n0 + 2 + i];
        expect_word(1'b0, comp);
        expect_word(1'b0, wc);
`endif
        checks++; if (fe_pulses - fe0 !== fe_exp) begin errors++; $display("FAIL ferr_pulses: got %0d expected %0d", fe_pulses - fe0, fe_exp); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ferr_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i].ch !== exp_q[i].ch) begin errors++; $display("FAIL ferr_ch[%0d]: got %b expected %b", i, got_q[i].ch, exp_q[i].ch); end
            checks++; if (got_q[i].l !== exp_q[i].l) begin errors++; $display("FAIL ferr_left[%0d]: got %h expected %h", i, got_q[i].l, exp_q[i].l); end
            checks++; if (got_q[i].r !== exp_q[i].r) begin errors++; $display("FAIL ferr_right[%0d]: got %h expected %h", i, got_q[i].r, exp_q[i].r); end
        end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_final: got %b expected 0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_loopback();
        test_random();
        test_reset_mid_word();
        test_frame_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 24, sample word width in bits (valid range 8..32).
REQ-002 SHALL have parameter LEFT_LR, default 1'b0, the lrclk level that denotes the left channel.
REQ-003 SHALL have input sclk, 1 bit, the only clock; all logic on its rising edge.
REQ-004 SHALL have input rst, 1 bit, reset, asynchronous, active-high.
REQ-005 SHALL have input lrclk, 1 bit, word-select from the I2S master.
REQ-006 SHALL have input sdin, 1 bit, serial data, MSB first.
REQ-007 SHALL have output left_data, DATA_W bits, last complete left word.
REQ-008 SHALL have output right_data, DATA_W bits, last complete right word.
REQ-009 SHALL have output data_valid, 1 bit, one-cycle pulse when a word completes.
REQ-010 SHALL have output data_ch, 1 bit, channel of the completed word: 0 = left, 1 = right.
REQ-011 SHALL have output frame_err, 1 bit, one-cycle pulse on a truncated word (see Configuration).

Function
REQ-012 SHALL register lrclk into prev_lr every cycle; an edge is detected when prev_lr differs from lrclk.
REQ-013 SHALL use states IDLE, DELAY and CAPTURE.
REQ-014 SHALL move IDLE -> DELAY on the edge-detect cycle and latch the word's channel: left if lrclk == LEFT_LR.
REQ-015 SHALL spend exactly one cycle in DELAY (the transmitter one-bit delay), then enter CAPTURE with the bit counter = DATA_W-1.
REQ-016 SHALL in CAPTURE shift sdin into the LSB of the shift register each cycle and decrement the counter; the first sample is the MSB.
REQ-017 SHALL on the sample where the counter = 0 load the full word into left_data or right_data per the latched channel, and return to IDLE.
REQ-018 SHALL assert data_valid for exactly the one cycle after that final sample, with data_ch set for that same cycle.
REQ-019 SHALL hold the other channel's register unchanged.
REQ-020 SHALL sample the DATA_W bits at rising edges N+2 .. N+DATA_W+1, where N is the edge-detect edge.
REQ-021 SHALL ignore lrclk edges that arrive in IDLE after word completion until the next edge detect; bits beyond DATA_W in a slot are discarded.
REQ-022 SHALL ignore sdin outside CAPTURE.
REQ-023 SHALL treat an unknown or illegal state as IDLE on the next edge.

Reset
REQ-024 SHALL on rst clear left_data, right_data, the shift register and the counter to 0.
REQ-025 SHALL on rst drive data_valid = 0, data_ch = 0 and frame_err = 0, and set the state to IDLE.
REQ-026 SHALL on rst load prev_lr from lrclk, so release of reset is never taken as an edge.
REQ-027 SHALL on rst mid-word discard the partial word with no data_valid pulse; capture restarts only at the next lrclk edge after release.

Configuration
REQ-028 SHALL gate the frame-error check with macro I2S_RX_FRAME_ERR_EN.
REQ-029 With I2S_RX_FRAME_ERR_EN defined, an lrclk edge during DELAY or CAPTURE SHALL discard the partial word (no data_valid) and pulse frame_err for one cycle.
REQ-030 With I2S_RX_FRAME_ERR_EN defined, that same edge SHALL restart in DELAY for the new channel.
REQ-031 Without I2S_RX_FRAME_ERR_EN, lrclk edges during DELAY or CAPTURE SHALL be ignored, the word SHALL complete normally, and frame_err SHALL be tied 0.

Verification
REQ-032 Reset with lrclk = 1, release, hold lrclk stable for 40 cycles -> no data_valid, all outputs 0.
REQ-033 Drive left 24'hA5C3F1 then right 24'h123456 in standard I2S timing -> left_data = A5C3F1 with data_valid/data_ch = 0, then right_data = 123456 with data_valid/data_ch = 1, each pulse exactly 1 cycle.
REQ-034 Loop back from the team's i2s_transmitter with data 24'h800001 on 32-sclk slots -> every received word = 800001 and both channels match.
REQ-035 Assert rst at bit 10 of a left word -> no data_valid pulse and left_data stays 0; the next right word is captured correctly.
REQ-036 With the macro defined, toggle lrclk at bit 12 -> frame_err pulses 1 cycle, no data_valid, and the following full word is captured.
REQ-037 With the macro undefined, repeat the REQ-036 stimulus -> the word completes and frame_err stays 0.
